// File: rtl/simon_pkg.sv
// Shared SIMON definitions: engine states, default geometry, rotate helper and
// the z constant sequence consumed by the key expansion.
package simon_pkg;

    localparam int N_DEF = 16;
    localparam int M_DEF = 4;
    localparam int T_DEF = 32;
    localparam int C_DEF = 5;

    // z0 for SIMON32/64; bit j is the j-th element of the sequence.
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        ROUND    = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Rotate the low w bits of v left by s; v must already fit in w bits.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int w, input int s);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((v << s) | (v >> (w - s))) & mask;
    endfunction

endpackage

// File: rtl/simon_round_fn.sv
// One SIMON Feistel round, combinational. dir = 0 encrypts, dir = 1 undoes
// an encrypt round with the same key.
module simon_round_fn
    import simon_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] key,
    input  logic         dir,
    output logic [N-1:0] x_next,
    output logic [N-1:0] y_next
);

    function automatic logic [N-1:0] f(input logic [N-1:0] v);
        logic [N-1:0] r1, r2, r8;
        r1 = N'(rotl(64'(v), N, 1));
        r2 = N'(rotl(64'(v), N, 2));
        r8 = N'(rotl(64'(v), N, 8));
        return (r1 & r8) ^ r2;
    endfunction

    always_comb begin
        x_next = y ^ f(x) ^ key;
        y_next = x;
        if (dir) begin
            x_next = y;
            y_next = x ^ f(y) ^ key;
        end
    end

endmodule

// File: rtl/simon_round_engine.sv
// SIMON block engine: walks the round-key schedule via count and runs one
// round per clock, forward for encrypt and backward for decrypt.
module simon_round_engine
    import simon_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int T = T_DEF,
    parameter int C = C_DEF
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                start,
    input  logic                decrypt,
    input  logic [1:0][N-1:0]   din,
    input  logic                doneKey,
    input  logic [N-1:0]        rKey,
    input  logic                ack,
    output logic [C-1:0]        count,
    output logic                busy,
    output logic                dout_valid,
    output logic [1:0][N-1:0]   dout,
    output logic                abort
);

    if (((1 << C) < T) || (M < 2) || (M > 4)) begin : g_bad_cfg
        $error("simon_round_engine: count too narrow for T or unsupported M");
    end

    state_t       state, state_next;
    logic [N-1:0] x_q, y_q, x_n, y_n;
    logic         dir_q;
    logic [C-1:0] count_q;
    logic         last;

    assign last  = dir_q ? (count_q == '0) : (count_q == C'(T - 1));
    assign count = count_q;

    simon_round_fn #(.N(N)) u_round (
        .x      (x_q),
        .y      (y_q),
        .key    (rKey),
        .dir    (dir_q),
        .x_next (x_n),
        .y_next (y_n)
    );

    always_ff @(posedge clk) begin
        if (!nR) state <= IDLE;
        else     state <= state_next;
    end

    // A falling doneKey in ROUND is a rekey: drop the run without a round.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = doneKey ? ROUND : WAIT_KEY;
            WAIT_KEY: if (doneKey) state_next = ROUND;
            ROUND: begin
                if (!doneKey)  state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE:     if (ack) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        dout_valid = (state == DONE);
        abort      = (state == ROUND) && !doneKey;
        dout       = '0;
        if (state == DONE) begin
            dout[1] = x_q;
            dout[0] = y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q     <= din[1];
                        y_q     <= din[0];
                        dir_q   <= decrypt;
                        count_q <= decrypt ? C'(T - 1) : '0;
                    end
                end
                ROUND: begin
                    if (doneKey) begin
                        x_q <= x_n;
                        y_q <= y_n;
                        if (!last) count_q <= dir_q ? count_q - 1'b1 : count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_engine.sv
// Directed bench for simon_round_engine against a SIMON32/64 reference model.
module tb_simon_round_engine;

    localparam logic [61:0] Z_SEQ = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [31:0] PT = 32'h6565_6877;
    localparam logic [31:0] CT = 32'hc69b_e9bb;

    logic             clk = 1'b0;
    logic             nR = 1'b0;
    logic             start = 1'b0;
    logic             decrypt = 1'b0;
    logic [1:0][15:0] din = '0;
    logic             doneKey = 1'b1;
    logic [15:0]      rKey;
    logic             ack = 1'b0;
    logic [4:0]       count;
    logic             busy;
    logic             dout_valid;
    logic [1:0][15:0] dout;
    logic             abort;

    logic [15:0] ks [0:31];
    assign rKey = ks[count];

    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_valid = 1'b0, exp_abort = 1'b0;
    logic [4:0]  exp_count = '0;
    logic [31:0] exp_dout = '0;
    int          n_vec = 0, n_err = 0;

    simon_round_engine dut (
        .clk        (clk),
        .nR         (nR),
        .start      (start),
        .decrypt    (decrypt),
        .din        (din),
        .doneKey    (doneKey),
        .rKey       (rKey),
        .ack        (ack),
        .count      (count),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout       (dout),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] rl(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] rr(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [15:0] fm(input logic [15:0] v);
        return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] blk);
        logic [15:0] x, y, t;
        x = blk[31:16];
        y = blk[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ fm(x) ^ ks[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] model_dec(input logic [31:0] blk);
        logic [15:0] x, y, t;
        x = blk[31:16];
        y = blk[15:0];
        for (int i = 31; i >= 0; i--) begin
            t = y;
            y = x ^ fm(y) ^ ks[i];
            x = t;
        end
        return {x, y};
    endfunction

    task automatic expand_key(input logic [63:0] key);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) ks[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rr(ks[i-1], 3) ^ ks[i-3];
            t = t ^ rr(t, 1);
            ks[i] = ~ks[i-4] ^ t ^ {15'b0, Z_SEQ[(i-4) % 62]} ^ 16'd3;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("dout_valid", 32'(dout_valid), 32'(exp_valid));
            check("abort", 32'(abort), 32'(exp_abort));
            check("count", 32'(count), 32'(exp_count));
            check("dout", dout, exp_dout);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One block: optional doneKey delay, optional rekey at round kill_at,
    // optional ack delay, optional ignored start pulses (poke).
    task automatic run(input bit dec, input logic [31:0] blk, input int key_wait,
                       input int kill_at, input int ack_wait, input bit poke);
        logic [31:0] res;
        res     = dec ? model_dec(blk) : model_enc(blk);
        start   = 1'b1;
        decrypt = dec;
        din     = blk;
        doneKey = (key_wait == 0);
        step();
        start     = 1'b0;
        decrypt   = 1'b0;
        din       = '0;
        exp_busy  = 1'b1;
        exp_count = dec ? 5'd31 : 5'd0;
        if (key_wait > 0) begin
            repeat (key_wait) step();
            doneKey = 1'b1;
            step();
        end
        for (int r = 0; r < 32; r++) begin
            if (r == kill_at) begin
                doneKey   = 1'b0;
                exp_abort = 1'b1;
                step();
                doneKey   = 1'b1;
                exp_abort = 1'b0;
                exp_busy  = 1'b0;
                step();
                return;
            end
            if (poke && r == 5) start = 1'b1;
            step();
            start = 1'b0;
            if (r == 31) begin
                exp_valid = 1'b1;
                exp_dout  = res;
            end else begin
                exp_count = dec ? 5'(exp_count - 5'd1) : 5'(exp_count + 5'd1);
            end
        end
        for (int a = 0; a < ack_wait; a++) begin
            if (poke && a == 1) start = 1'b1;
            step();
            start = 1'b0;
        end
        ack   = 1'b1;
        start = poke;
        step();
        ack       = 1'b0;
        start     = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_dout  = '0;
        step();
    endtask

    initial begin
        expand_key(64'h1918_1110_0908_0100);
        check("model_enc_pin", model_enc(PT), CT);
        check("model_dec_pin", model_dec(CT), PT);
        check("model_roundtrip", model_dec(model_enc(32'hdead_beef)), 32'hdead_beef);

        nR = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        nR = 1'b1;
        step();

        run(1'b0, PT, 0, -1, 0, 1'b0);
        run(1'b1, CT, 0, -1, 0, 1'b0);
        run(1'b0, PT, 10, -1, 0, 1'b0);
        run(1'b0, PT, 0, 10, 0, 1'b0);
        run(1'b0, PT, 0, -1, 0, 1'b0);
        run(1'b1, CT, 0, -1, 5, 1'b1);
        run(1'b0, 32'h0000_0000, 0, -1, 1, 1'b0);
        run(1'b1, 32'hffff_ffff, 0, -1, 2, 1'b0);

        // reset in the middle of an encrypt run
        start   = 1'b1;
        decrypt = 1'b0;
        din     = PT;
        step();
        start     = 1'b0;
        exp_busy  = 1'b1;
        exp_count = 5'd0;
        repeat (16) begin
            step();
            exp_count = 5'(exp_count + 5'd1);
        end
        nR = 1'b0;
        step();
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        exp_count = 5'd0;
        exp_dout  = '0;
        nR = 1'b1;
        step();
        run(1'b0, PT, 0, -1, 0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/simon_round_engine.md
# simon_round_engine

Consumer end of the SIMON round-key interface: indexes the expanded key schedule through `count`, reads `rKey` combinationally, and runs one Feistel round per clock to encrypt or decrypt a 2N-bit block. It sits between the block I/O and the key expansion, which owns the key schedule and asserts `doneKey` once all T round keys are stored. Decryption reads the schedule in reverse order, so both directions share one datapath.

## Interface
- `N`, 16, word size in bits (block = 2N)
- `M`, 4, key words; unused by the datapath, passed through for consistency
- `T`, 32, round count
- `C`, 5, `count` width; 2^C >= T
- `clk`  in  1  single clock, rising edge
- `nR`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `decrypt`  in  1  direction, sampled with `start` (1 = decrypt)
- `din`  in  [1:0][N-1:0]  input block, sampled with `start`; `din[1]` = x (left), `din[0]` = y (right)
- `doneKey`  in  1  key schedule complete and stable
- `rKey`  in  N  round key for the current `count`, combinational from the key expansion
- `ack`  in  1  consumer has taken `dout`
- `count`  out  C  round-key index driven to the key expansion
- `busy`  out  1  high in WAIT_KEY, ROUND and DONE
- `dout_valid`  out  1  `dout` holds a result
- `dout`  out  [1:0][N-1:0]  result block, same x/y layout as `din`
- `abort`  out  1  one-cycle pulse when a run is cancelled

## Operation
- Reset (`nR` = 0 at a clk edge): state IDLE, `count` = 0, `busy` = 0, `dout_valid` = 0, `abort` = 0, `dout` = 0, x/y registers = 0.
- f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x), all N bits.
- Encrypt round: (x, y) <- (y ^ f(x) ^ rKey, x). `count` steps 0 up to T-1.
- Decrypt round: (x, y) <- (y, x ^ f(y) ^ rKey). `count` steps T-1 down to 0.
- States:
  - IDLE: on `start`, latch `din` into x/y, latch `decrypt`, and load `count` with 0 for encrypt or T-1 for decrypt. Go to ROUND if `doneKey` = 1, otherwise go to WAIT_KEY.
  - WAIT_KEY: hold until `doneKey` = 1, then go to ROUND.
  - ROUND: one round per cycle using the current `rKey`, then step `count`. After the round at the last index (T-1 for encrypt, 0 for decrypt), go to DONE. `count` does not step past the end, so it stays within 0..T-1.
  - DONE: `dout` = {x, y}, `dout_valid` = 1. On `ack`, clear `dout_valid` and go to IDLE.
- `start` outside IDLE is ignored, including a `start` in the same cycle as `ack`.
- If `doneKey` falls during ROUND (rekey), the run is cancelled: pulse `abort` for 1 cycle, go to IDLE, and do not assert `dout_valid`. In WAIT_KEY a low `doneKey` is simply waited on.
- Rounds never execute while `doneKey` = 0.

## Timing
- `start` accepted at edge 0 with `doneKey` = 1: rounds run at edges 1..T and `dout_valid` rises after edge T. Latency is T+1 cycles, which is 33 at the defaults.
- `count` is registered. `rKey` must settle within the same cycle.
- `dout` is stable while `dout_valid` = 1.
- Earliest next `start` is the cycle after `ack`, so back-to-back throughput is T+2 cycles per block.
- Reset asserted mid-run takes priority over everything and returns to the reset values at that edge.

## Structure
- Shared package `simon_pkg`:
  - state enum {IDLE, WAIT_KEY, ROUND, DONE}
  - default N/M/T/C constants
  - rotate-left function
  - the 62-bit z sequence, shared with the key expansion
- One sub-module, `simon_round_fn`: combinational; inputs x, y, key, dir; outputs the next x and y.
- Engine top: FSM, x/y registers, count logic.

## Test plan
- SIMON32/64 encrypt: key words key[3..0] = 1918, 1110, 0908, 0100 (hex); `din` = {6565, 6877} -> `dout` = {c69b, e9bb} exactly 33 cycles after `start`, with `count` sequence 0..31.
- Decrypt with the same key: `din` = {c69b, e9bb} -> `dout` = {6565, 6877}, with `count` sequence 31..0.
- `start` while `doneKey` = 0 for 10 cycles: engine stays in WAIT_KEY with `count` held, no rounds run; then encrypt completes correctly 33 cycles after `doneKey` rises.
- Rekey mid-run (`doneKey` low at round 10): `abort` pulses once, engine returns to IDLE, `dout_valid` never asserts, the next run is correct.
- `start` pulsed during ROUND and during DONE: ignored, result unchanged. `ack` delayed 5 cycles: `dout` held and `dout_valid` stays high throughout.
- `nR` low at round 16, then released: all outputs 0, state IDLE; a fresh encrypt yields c69b/e9bb.
